// File: rtl/datapath.sv
// Accumulator-machine datapath: instruction register, program counter,
// accumulator with add/sub ALU, and a 32-word synchronous-read memory
// with a program-preload write port.
module datapath #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  IRload,
  input  logic                  JMPmux,
  input  logic                  PCload,
  input  logic                  Meminst,
  input  logic                  MemWr,
  input  logic                  Aload,
  input  logic                  Sub,
  input  logic [1:0]            Asel,
  input  logic [DATA_WIDTH-1:0] Input,
  input  logic                  progWr,
  input  logic [ADDR_WIDTH-1:0] progAddr,
  input  logic [DATA_WIDTH-1:0] progData,
  output logic [2:0]            IR,
  output logic                  Aeq0,
  output logic                  Apos,
  output logic [DATA_WIDTH-1:0] A,
  output logic [ADDR_WIDTH-1:0] PC
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned OP_BITS = 3;

  localparam logic [1:0] ASEL_ALU  = 2'b00;
  localparam logic [1:0] ASEL_IN   = 2'b01;
  localparam logic [1:0] ASEL_MEM  = 2'b10;
  localparam logic [1:0] ASEL_ZERO = 2'b11;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] ir_reg;
  logic [DATA_WIDTH-1:0] dout;

  logic [ADDR_WIDTH-1:0] addr_c;
  logic [ADDR_WIDTH-1:0] ir_addr_c;
  logic                  wr_en_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [DATA_WIDTH-1:0] alu_c;
  logic [DATA_WIDTH-1:0] a_next_c;

  // Address mux, write arbitration (preload port beats datapath store) and ALU
  always_comb begin
    ir_addr_c = ir_reg[ADDR_WIDTH-1:0];
    addr_c    = Meminst ? ir_addr_c : PC;
    wr_en_c   = progWr | MemWr;
    wr_addr_c = progWr ? progAddr : addr_c;
    wr_data_c = progWr ? progData : A;
    alu_c     = Sub ? DATA_WIDTH'(A - dout) : DATA_WIDTH'(A + dout);
    case (Asel)
      ASEL_ALU:  a_next_c = alu_c;
      ASEL_IN:   a_next_c = Input;
      ASEL_MEM:  a_next_c = dout;
      ASEL_ZERO: a_next_c = '0;
      default:   a_next_c = '0;
    endcase
  end

  // Memory array: contents survive reset, but no write lands while reset is high
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // contents intentionally retained
    end else if (wr_en_c) begin
      mem[wr_addr_c] <= wr_data_c;
    end
  end

  // Synchronous read port, IR, PC and accumulator registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout   <= '0;
      ir_reg <= '0;
      PC     <= '0;
      A      <= '0;
    end else begin
      dout <= mem[addr_c];
      if (IRload) begin
        ir_reg <= dout;
      end
      if (PCload) begin
        PC <= JMPmux ? ir_addr_c : ADDR_WIDTH'(PC + ADDR_WIDTH'(1));
      end
      if (Aload) begin
        A <= a_next_c;
      end
    end
  end

  // Opcode and accumulator status for the control unit
  always_comb begin
    IR   = ir_reg[DATA_WIDTH-1 -: OP_BITS];
    Aeq0 = (A == '0);
    Apos = ~A[DATA_WIDTH-1] & (A != '0);
  end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: drives whole instructions as strobe sequences,
// predicts architectural state with an instruction-level model, and a monitor
// compares whenever the driver flags a checkpoint.
module tb_datapath;

  logic       clock;
  logic       reset;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub;
  logic [1:0] Asel;
  logic [7:0] Input;
  logic       progWr;
  logic [4:0] progAddr;
  logic [7:0] progData;
  logic [2:0] IR;
  logic       Aeq0, Apos;
  logic [7:0] A;
  logic [4:0] PC;

  datapath dut (
    .clock(clock), .reset(reset),
    .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload), .Meminst(Meminst),
    .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Input(Input),
    .progWr(progWr), .progAddr(progAddr), .progData(progData),
    .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .A(A), .PC(PC)
  );

  // Instruction set used by the bench to give the strobes meaning
  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_JZ    = 3'd5;
  localparam logic [2:0] OP_INPUT = 3'd6;
  localparam logic [2:0] OP_CLR   = 3'd7;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [4:0] pc;
    logic [2:0] ir;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic chk;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [7:0] mem_m [0:31];
  logic [7:0] a_m;
  logic [4:0] pc_m;
  logic [2:0] ir_m;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sbq.size());
    $fatal(1, "watchdog");
  end

  // Monitor: pops one expectation per flagged checkpoint
  always @(negedge clock) begin
    if (chk) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: checkpoint with empty expectation queue");
      end else begin
        mon_e = sbq.pop_front();
        if (A !== mon_e.a || PC !== mon_e.pc || IR !== mon_e.ir ||
            Aeq0 !== (mon_e.a == 8'h00) ||
            Apos !== (mon_e.a != 8'h00 && mon_e.a < 8'h80)) begin
          n_fail++;
          $display("FAIL %s: got A=%h PC=%0d IR=%0d Aeq0=%b Apos=%b, expected A=%h PC=%0d IR=%0d Aeq0=%b Apos=%b",
                   mon_e.name, A, PC, IR, Aeq0, Apos, mon_e.a, mon_e.pc, mon_e.ir,
                   (mon_e.a == 8'h00), (mon_e.a != 8'h00 && mon_e.a < 8'h80));
        end
      end
    end
  end

  task automatic idle();
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0;
    Aload = 0; Sub = 0; Asel = 2'b00; Input = 8'h00;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic checkpoint(input string nm);
    exp_t e;
    e.name = nm; e.a = a_m; e.pc = pc_m; e.ir = ir_m;
    sbq.push_back(e);
    chk = 1'b1;
    @(negedge clock);
    #1;
    chk = 1'b0;
  endtask

  task automatic set_mem(input logic [4:0] ad, input logic [7:0] d);
    progWr = 1'b1; progAddr = ad; progData = d;
    cyc();
    progWr = 1'b0;
    if (!reset) mem_m[ad] = d;
  endtask

  // Places the instruction at PC, then start / fetch / decode / execute
  task automatic run_instr(input logic [2:0] op, input logic [4:0] ad,
                           input logic [7:0] inval, input logic pw,
                           input logic [4:0] pwa, input logic [7:0] pwd,
                           input string nm);
    logic [7:0] opnd;
    set_mem(pc_m, {op, ad});
    idle();
    cyc();                                   // start
    IRload = 1; PCload = 1; JMPmux = 0;
    cyc();                                   // fetch
    idle();
    ir_m = op;
    pc_m = pc_m + 5'd1;
    Meminst = 1;
    cyc();                                   // decode
    opnd = mem_m[ad];
    case (op)
      OP_LOAD:  begin Aload = 1; Asel = 2'b10; end
      OP_STORE: MemWr = 1;
      OP_ADD:   begin Aload = 1; Asel = 2'b00; Sub = 0; end
      OP_SUB:   begin Aload = 1; Asel = 2'b00; Sub = 1; end
      OP_JMP:   begin PCload = 1; JMPmux = 1; end
      OP_JZ:    begin PCload = (a_m == 8'h00); JMPmux = 1; end
      OP_INPUT: begin Aload = 1; Asel = 2'b01; Input = inval; end
      default:  begin Aload = 1; Asel = 2'b11; end
    endcase
    if (pw) begin progWr = 1; progAddr = pwa; progData = pwd; end
    cyc();                                   // execute
    idle();
    progWr = 0;
    case (op)
      OP_LOAD:  a_m = opnd;
      OP_STORE: mem_m[ad] = a_m;
      OP_ADD:   a_m = a_m + opnd;
      OP_SUB:   a_m = a_m - opnd;
      OP_JMP:   pc_m = ad;
      OP_JZ:    if (a_m == 8'h00) pc_m = ad;
      OP_INPUT: a_m = inval;
      default:  a_m = 8'h00;
    endcase
    if (pw) mem_m[pwa] = pwd;
    checkpoint(nm);
  endtask

  // STORE whose execute cycle is cut short by reset
  task automatic store_with_reset(input logic [4:0] ad);
    set_mem(pc_m, {OP_STORE, ad});
    idle();
    cyc();
    IRload = 1; PCload = 1;
    cyc();
    idle();
    Meminst = 1;
    cyc();
    MemWr = 1;
    @(negedge clock);
    reset = 1'b1;
    cyc();
    idle();
    a_m = 8'h00; pc_m = 5'd0; ir_m = 3'd0;
    checkpoint("reset_mid_store");
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    logic [2:0] rop;
    chk = 1'b0;
    idle();
    progWr = 0; progAddr = '0; progData = '0;
    reset = 1'b1;
    a_m = 8'h00; pc_m = 5'd0; ir_m = 3'd0;
    repeat (2) cyc();
    checkpoint("reset_state");
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 32; i++) set_mem(5'(i), 8'($urandom));
    set_mem(5'd5, 8'h2A);
    set_mem(5'd3, 8'h11);
    reset = 1'b1;
    set_mem(5'd3, 8'h77);                    // must be ignored under reset
    checkpoint("reset_again");
    reset = 1'b0;
    cyc();

    run_instr(OP_LOAD, 5'd5, 8'h00, 0, 5'd0, 8'h00, "load5_after_preload");
    run_instr(OP_LOAD, 5'd3, 8'h00, 0, 5'd0, 8'h00, "progwr_ignored_in_reset");

    set_mem(5'd10, 8'h7F);
    run_instr(OP_LOAD, 5'd10, 8'h00, 0, 5'd0, 8'h00, "load_7f");
    set_mem(5'd6, 8'h01);
    run_instr(OP_ADD, 5'd6, 8'h00, 0, 5'd0, 8'h00, "add_wrap_to_80");
    run_instr(OP_SUB, 5'd6, 8'h00, 0, 5'd0, 8'h00, "sub_back_to_7f");

    set_mem(5'd11, 8'h03);
    run_instr(OP_LOAD, 5'd11, 8'h00, 0, 5'd0, 8'h00, "load_03");
    set_mem(5'd7, 8'h03);
    run_instr(OP_SUB, 5'd7, 8'h00, 0, 5'd0, 8'h00, "sub_to_zero");
    run_instr(OP_JZ, 5'd20, 8'h00, 0, 5'd0, 8'h00, "jz_taken_20");

    set_mem(5'd12, 8'h55);
    run_instr(OP_LOAD, 5'd12, 8'h00, 0, 5'd0, 8'h00, "load_55");
    run_instr(OP_STORE, 5'd9, 8'h00, 1, 5'd9, 8'hAA, "store_vs_progwr");
    run_instr(OP_LOAD, 5'd9, 8'h00, 0, 5'd0, 8'h00, "progwr_wins");

    run_instr(OP_JMP, 5'd31, 8'h00, 0, 5'd0, 8'h00, "jmp_31");
    run_instr(OP_LOAD, 5'd12, 8'h00, 0, 5'd0, 8'h00, "pc_wrap_31_to_0");

    set_mem(5'd13, 8'h3C);
    store_with_reset(5'd13);
    run_instr(OP_LOAD, 5'd13, 8'h00, 0, 5'd0, 8'h00, "aborted_store_no_write");

    run_instr(OP_INPUT, 5'd0, 8'hF0, 0, 5'd0, 8'h00, "input_f0");
    run_instr(OP_JZ, 5'd25, 8'h00, 0, 5'd0, 8'h00, "jz_not_taken");
    run_instr(OP_CLR, 5'd0, 8'h00, 0, 5'd0, 8'h00, "clear_a");

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) set_mem(5'($urandom), 8'($urandom));
      rop = 3'($urandom_range(0, 7));
      run_instr(rop, 5'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                5'($urandom), 8'($urandom), $sformatf("random_%0d_op%0d", i, rop));
    end

    repeat (3) cyc();
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
